// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, odd-parity shifting on device
// clock falling edges and ACK check, behind an 8-bit CPU register port.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  output logic       irq,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       tx_active
);

  localparam int MAX_CYC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_CYC) + 1;
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_SHIFT,
    S_ACK,
    S_ERR
  } state_t;

  state_t        r_state;
  logic [7:0]    r_tx_byte;
  logic [3:0]    r_bitcnt;
  logic [CW-1:0] r_cnt;
  logic          r_clk_s1, r_clk_s2, r_clk_prev;
  logic          r_dat_s1, r_dat_s2;
  logic          r_tiq, r_tie, r_ovr, r_ter, r_nak;

  logic          w_fe;
  logic          w_wr_data, w_wr_ctrl, w_rd, w_rd_stat;
  logic          w_timeout;
  logic [7:0]    w_status;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // Synchronizers idle high so the released bus never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk_in;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_dat_in;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fe      = r_clk_prev & ~r_clk_s2;
  assign w_wr_data = cs & ~rw & ~AD;
  assign w_wr_ctrl = cs & ~rw & AD;
  assign w_rd      = cs & rw;
  assign w_rd_stat = w_rd & AD;
  assign w_timeout = (r_cnt >= TO_LAST);
  assign w_status  = {r_tiq, r_tie, 2'b00, r_ovr, r_ter, r_nak, tx_active};
  assign irq       = r_tiq & r_tie;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_tx_byte  <= '0;
      r_bitcnt   <= '0;
      r_cnt      <= '0;
      r_tiq      <= 1'b0;
      r_tie      <= 1'b0;
      r_ovr      <= 1'b0;
      r_ter      <= 1'b0;
      r_nak      <= 1'b0;
      DO         <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_active  <= 1'b0;
    end else begin
      if (w_rd) begin
        DO <= AD ? w_status : r_tx_byte;
      end
      if (w_wr_ctrl) begin
        r_tie <= DI[6];
      end
      // Clears come first so a same-cycle set from the FSM below overrides them.
      if (w_rd_stat) begin
        r_tiq <= 1'b0;
        r_ovr <= 1'b0;
        r_ter <= 1'b0;
        r_nak <= 1'b0;
      end
      if (w_wr_data && (r_state != S_IDLE)) begin
        r_ovr <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_wr_data) begin
            r_tx_byte  <= DI;
            r_cnt      <= '0;
            ps2_clk_oe <= 1'b1;
            tx_active  <= 1'b1;
            r_state    <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (r_cnt >= INH_LAST) begin
            ps2_dat_oe <= 1'b1;
            r_state    <= S_START;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end

        S_START: begin
          r_bitcnt   <= '0;
          r_cnt      <= '0;
          ps2_clk_oe <= 1'b0;
          r_state    <= S_SHIFT;
        end

        S_SHIFT: begin
          if (w_fe) begin
            r_cnt    <= '0;
            r_bitcnt <= r_bitcnt + 4'd1;
            if (r_bitcnt < 4'd8) begin
              ps2_dat_oe <= ~r_tx_byte[r_bitcnt[2:0]];
            end else if (r_bitcnt == 4'd8) begin
              // Odd parity bit is ~^byte, and the pin is driven with its inverse.
              ps2_dat_oe <= ^r_tx_byte;
            end else begin
              ps2_dat_oe <= 1'b0;
              r_state    <= S_ACK;
            end
          end else if (w_timeout) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            r_state    <= S_ERR;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end

        S_ACK: begin
          if (w_fe) begin
            if (r_dat_s2) begin
              r_nak <= 1'b1;
            end
            r_tiq     <= 1'b1;
            tx_active <= 1'b0;
            r_state   <= S_IDLE;
          end else if (w_timeout) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            r_state    <= S_ERR;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end

        S_ERR: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          r_ter      <= 1'b1;
          r_tiq      <= 1'b1;
          tx_active  <= 1'b0;
          r_state    <= S_IDLE;
        end

        default: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          tx_active  <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model drives the open-drain pins and a
// time-based reference model predicts the host pin enables on every cycle.
module tb_ps2_host_tx;

  localparam int INH = 50;
  localparam int TO  = 400;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       AD, rw, cs;
  logic [7:0] DI, DO;
  logic       irq;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe, tx_active;
  logic       dev_clk, dev_dat;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  // Reference model: write edge, byte and the cycle of each device falling edge.
  bit         m_valid;
  int         m_w;
  logic [7:0] m_byte;
  int         ft[11];
  int         m_nf;

  logic [7:0] rd;
  int         wn;
  logic [9:0] s;
  logic [7:0] rb;
  logic       rak, rtie;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .AD         (AD),
    .DI         (DI),
    .DO         (DO),
    .rw         (rw),
    .cs         (cs),
    .irq        (irq),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .tx_active  (tx_active)
  );

  assign ps2_clk_in = ~ps2_clk_oe & dev_clk;
  assign ps2_dat_in = ~ps2_dat_oe & dev_dat;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic exp_bit(input int k, input logic [7:0] b);
    if (k < 8) return b[k];
    if (k == 8) return ~^b;
    return 1'b1;
  endfunction

  // First edge after which the host is idle again (ACK edge, or timeout + ERR).
  function automatic int m_done();
    int last;
    if (!m_valid) return 0;
    if (m_nf == 11) return ft[10] + 3;
    last = (m_nf == 0) ? (m_w + INH + 1) : (ft[m_nf-1] + 3);
    return last + TO + 1;
  endfunction

  function automatic logic exp_clk(input int c);
    return m_valid && (c >= m_w) && (c <= m_w + INH);
  endfunction

  function automatic logic exp_act(input int c);
    return m_valid && (c >= m_w) && (c < m_done());
  endfunction

  function automatic logic exp_dat(input int c);
    int d;
    int last;
    d = m_done();
    if (!m_valid || (c < m_w + INH) || (c >= d)) return 1'b0;
    if ((m_nf < 11) && (c >= d - 1)) return 1'b0;
    last = -1;
    for (int k = 0; k < m_nf; k++) begin
      if (ft[k] + 3 <= c) last = k;
    end
    if (last < 0) return 1'b1;
    if (last < 9) return ~exp_bit(last, m_byte);
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("pins", {29'd0, ps2_clk_oe, ps2_dat_oe, tx_active},
          {29'd0, exp_clk(cyc), exp_dat(cyc), exp_act(cyc)});
    end
  end

  task automatic cpu_wr(input logic ad, input logic [7:0] d);
    int e;
    @(posedge clk); #1;
    cs = 1'b1; rw = 1'b0; AD = ad; DI = d;
    e = cyc + 1;
    if (!ad && (!m_valid || (e - 1 >= m_done()))) begin
      m_valid = 1'b1; m_w = e; m_byte = d; m_nf = 0;
    end
    @(posedge clk); #1;
    cs = 1'b0;
  endtask

  task automatic cpu_rd(input logic ad, output logic [7:0] d);
    @(posedge clk); #1;
    cs = 1'b1; rw = 1'b1; AD = ad;
    @(posedge clk); #1;
    cs = 1'b0; rw = 1'b0;
    d = DO;
  endtask

  task automatic dev_xfer(input int nfall, input logic ack, input bit rd_done,
                          input logic [7:0] rd_exp, output int wait_n, output logic [9:0] bits);
    int lo, hi;
    bit ok;
    bits = '0; wait_n = 0; ok = 1'b0;
    lo = $urandom_range(10, 20);
    hi = $urandom_range(10, 20);
    for (int i = 0; i < INH + 20; i++) begin
      @(posedge clk); #1;
      if (ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) begin
        ok = 1'b1;
        break;
      end
      wait_n++;
    end
    if (!ok) begin
      chk("request_to_send_seen", 32'd0, 32'd1);
      return;
    end
    chk("start_bit", {31'd0, ps2_dat_in}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    for (int k = 0; k < nfall; k++) begin
      dev_clk = 1'b0; ft[k] = cyc; m_nf = k + 1;
      for (int j = 1; j <= lo; j++) begin
        @(posedge clk); #1;
        if (k == 10 && rd_done) begin
          if (j == 2) begin
            cs = 1'b1; rw = 1'b1; AD = 1'b1;
          end else if (j == 3) begin
            cs = 1'b0; rw = 1'b0;
            chk("read_at_tiq_set", {24'd0, DO}, {24'd0, rd_exp});
          end
        end
      end
      dev_clk = 1'b1;
      for (int j = 1; j <= hi; j++) begin
        @(posedge clk); #1;
        if (j == hi / 2 && k < 10) begin
          bits[k] = ps2_dat_in;
          chk($sformatf("bit%0d", k), {31'd0, bits[k]}, {31'd0, exp_bit(k, m_byte)});
          if (k == 9) dev_dat = ack;
        end
      end
    end
    dev_dat = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog at cycle %0d", cyc);
    $fatal(1, "bench did not complete in time");
  end

  initial begin
    cs = 1'b0; rw = 1'b0; AD = 1'b0; DI = '0;
    dev_clk = 1'b1; dev_dat = 1'b1;
    m_valid = 1'b0; m_w = 0; m_byte = '0; m_nf = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    chk("rst_DO", {24'd0, DO}, 32'd0);
    chk("rst_pins", {28'd0, ps2_clk_oe, ps2_dat_oe, tx_active, irq}, 32'd0);
    cpu_rd(1'b1, rd); chk("rst_status", {24'd0, rd}, 32'h00);
    cpu_rd(1'b0, rd); chk("rst_data", {24'd0, rd}, 32'h00);

    // 0xED, ACK good, TIE=0
    cpu_wr(1'b0, 8'hED);
    dev_xfer(11, 1'b0, 1'b0, 8'h00, wn, s);
    chk("inhibit_len", wn, INH);
    chk("ed_frame", {22'd0, s}, {22'd0, 10'b1111101101});
    chk("ed_irq", {31'd0, irq}, 32'd0);
    cpu_rd(1'b1, rd); chk("ed_status", {24'd0, rd}, 32'h80);

    // 0x01 with TIE=1, device NAK
    cpu_wr(1'b1, 8'h40);
    cpu_wr(1'b0, 8'h01);
    dev_xfer(11, 1'b1, 1'b0, 8'h00, wn, s);
    chk("01_frame", {22'd0, s}, {22'd0, 10'b1000000001});
    chk("01_irq_set", {31'd0, irq}, 32'd1);
    cpu_rd(1'b1, rd); chk("01_status", {24'd0, rd}, 32'hC2);
    chk("01_irq_clr", {31'd0, irq}, 32'd0);
    cpu_rd(1'b1, rd); chk("01_status_clr", {24'd0, rd}, 32'h40);

    // 0x00, device silent: timeout
    cpu_wr(1'b0, 8'h00);
    repeat (INH + TO + 10) @(posedge clk);
    #1;
    chk("to_pins", {29'd0, ps2_clk_oe, ps2_dat_oe, tx_active}, 32'd0);
    chk("to_irq", {31'd0, irq}, 32'd1);
    cpu_rd(1'b1, rd); chk("to_status", {24'd0, rd}, 32'hC4);
    cpu_wr(1'b1, 8'h00);

    // 0xF4 with an overrun write during the shift
    cpu_wr(1'b0, 8'hF4);
    fork
      dev_xfer(11, 1'b0, 1'b0, 8'h00, wn, s);
      begin
        repeat (INH + 30) @(posedge clk);
        cpu_wr(1'b0, 8'h55);
      end
    join
    chk("f4_frame", {22'd0, s}, {22'd0, 10'b1011110100});
    cpu_rd(1'b1, rd); chk("f4_status", {24'd0, rd}, 32'h88);
    cpu_rd(1'b0, rd); chk("f4_data", {24'd0, rd}, 32'hF4);

    // Status read on the very edge TIQ is set
    cpu_wr(1'b0, 8'h3C);
    dev_xfer(11, 1'b0, 1'b1, 8'h01, wn, s);
    cpu_rd(1'b1, rd); chk("race_status", {24'd0, rd}, 32'h80);

    // Reset after the 4th device falling edge
    cpu_wr(1'b0, 8'hA7);
    dev_xfer(4, 1'b0, 1'b0, 8'h00, wn, s);
    @(posedge clk); #3;
    rst_n = 1'b0; m_valid = 1'b0;
    #1;
    chk("arst_pins", {29'd0, ps2_clk_oe, ps2_dat_oe, tx_active}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    cpu_rd(1'b1, rd); chk("arst_status", {24'd0, rd}, 32'h00);
    cpu_rd(1'b0, rd); chk("arst_data", {24'd0, rd}, 32'h00);
    cpu_wr(1'b0, 8'hFF);
    dev_xfer(11, 1'b0, 1'b0, 8'h00, wn, s);
    chk("ff_frame", {22'd0, s}, {22'd0, 10'b1111111111});
    cpu_rd(1'b1, rd); chk("ff_status", {24'd0, rd}, 32'h80);

    // Randomized transfers
    for (int n = 0; n < 6; n++) begin
      rb   = 8'($urandom_range(0, 255));
      rak  = 1'($urandom_range(0, 1));
      rtie = 1'($urandom_range(0, 1));
      cpu_wr(1'b1, {1'b0, rtie, 6'd0});
      cpu_wr(1'b0, rb);
      dev_xfer(11, rak, 1'b0, 8'h00, wn, s);
      chk("rnd_frame", {22'd0, s}, {22'd0, 1'b1, ~^rb, rb});
      chk("rnd_irq", {31'd0, irq}, {31'd0, rtie});
      cpu_rd(1'b1, rd);
      chk("rnd_status", {24'd0, rd}, {24'd0, 1'b1, rtie, 4'b0000, rak, 1'b0});
      cpu_rd(1'b1, rd);
      chk("rnd_status_clr", {24'd0, rd}, {24'd0, 1'b0, rtie, 6'd0});
      cpu_rd(1'b0, rd);
      chk("rnd_data", {24'd0, rd}, {24'd0, rb});
    end
    cpu_wr(1'b1, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
